// File: rtl/mdu_pkg.sv
// Shared RV32M definitions for the multiply/divide unit
// and its execute-stage issue controller.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_issue_ctrl_fastpath.sv
// Resolves divide-by-zero and signed-overflow cases
// without a trip through the mdu.
module mdu_fastpath
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        is_fast,
  output logic [31:0] fast_result
);

  logic by_zero;
  logic ovf;
  logic is_div;
  logic is_rem;

  assign by_zero = (rs2 == '0);
  assign ovf     = (rs1 == INT_MIN) && (rs2 == ALL_ONES);
  assign is_div  = (op == F3_DIV) || (op == F3_DIVU);
  assign is_rem  = (op == F3_REM) || (op == F3_REMU);

  // Pick the architecturally defined result for the corner cases
  always_comb begin
    is_fast     = 1'b0;
    fast_result = '0;
    if (by_zero && is_div) begin
      is_fast     = 1'b1;
      fast_result = ALL_ONES;
    end else if (by_zero && is_rem) begin
      is_fast     = 1'b1;
      fast_result = rs1;
    end else if (ovf && op == F3_DIV) begin
      is_fast     = 1'b1;
      fast_result = INT_MIN;
    end else if (ovf && op == F3_REM) begin
      is_fast     = 1'b1;
      fast_result = '0;
    end
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// EX-stage initiator for the mdu: issues requests, stalls
// the pipe, drains flushed ops and returns one writeback.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_mdu,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] mdu_rs1,
  output logic [31:0] mdu_rs2,
  output logic [2:0]  mdu_op,
  output logic        mdu_valid,
  input  logic [31:0] mdu_result,
  input  logic        mdu_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mdu_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  mdu_state_t     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [31:0]    wb_data_n;
  logic [31:0]    fast_result;
  logic           is_fast;
  logic           req;
  logic           issue;
  logic           rd_load;
  logic           err_set;
  logic           timeout;

  assign req     = ex_valid & ex_is_mdu & ~flush;
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  mdu_fastpath u_fast (
    .op          (ex_funct3),
    .rs1         (ex_rs1_val),
    .rs2         (ex_rs2_val),
    .is_fast     (is_fast),
    .fast_result (fast_result)
  );

  // Hold the pipe while an op is being accepted or is outstanding
  assign stall = (state == S_BUSY)
               | (req & ((state == S_IDLE) | (state == S_DRAIN)));

  assign wb_valid = (state == S_DONE);

  // Next-state, counter and writeback-data selection
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    wb_data_n = wb_data;
    issue     = 1'b0;
    rd_load   = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          rd_load = 1'b1;
          if (is_fast) begin
            wb_data_n = fast_result;
            state_n   = S_DONE;
          end else begin
            issue   = 1'b1;
            cnt_n   = '0;
            state_n = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_n = cnt + 1'b1;
        if (mdu_ready && flush) begin
          state_n = S_IDLE;
        end else if (mdu_ready) begin
          wb_data_n = mdu_result;
          state_n   = S_DONE;
        end else if (timeout) begin
          err_set = 1'b1;
          if (flush) begin
            state_n = S_IDLE;
          end else begin
            wb_data_n = '0;
            state_n   = S_DONE;
          end
        end else if (flush) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_n = cnt + 1'b1;
        if (mdu_ready) begin
          state_n = S_IDLE;
        end else if (timeout) begin
          err_set = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wb_data   <= '0;
      wb_rd     <= '0;
      mdu_rs1   <= '0;
      mdu_rs2   <= '0;
      mdu_op    <= '0;
      mdu_valid <= 1'b0;
      mdu_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wb_data   <= wb_data_n;
      mdu_valid <= issue;
      mdu_err   <= mdu_err | err_set;
      if (rd_load) begin
        wb_rd <= ex_rd;
      end
      if (issue) begin
        mdu_rs1 <= ex_rs1_val;
        mdu_rs2 <= ex_rs2_val;
        mdu_op  <= ex_funct3;
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: an RV32M
// reference model, a latency-programmable mdu, a scoreboard.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  logic        clk, rst;
  logic        ex_valid, ex_is_mdu, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [31:0] mdu_rs1, mdu_rs2;
  logic [2:0]  mdu_op;
  logic        mdu_valid;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_err;

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_is_mdu  (ex_is_mdu),
    .ex_funct3  (ex_funct3),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_rd      (ex_rd),
    .flush      (flush),
    .stall      (stall),
    .mdu_rs1    (mdu_rs1),
    .mdu_rs2    (mdu_rs2),
    .mdu_op     (mdu_op),
    .mdu_valid  (mdu_valid),
    .mdu_result (mdu_result),
    .mdu_ready  (mdu_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mdu_err    (mdu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          lat = 2;
  bit          exp_err = 1'b0;
  logic [31:0] last_wb = '0;
  logic [66:0] iss_q[$];
  logic [37:0] wb_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // RV32M semantics from the ISA definition
  function automatic logic [31:0] rv32m(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'b000: begin
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
      end
      3'b001: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[63:32];
      end
      3'b010: begin
        p = {{32{a[31]}}, a} * {32'b0, b};
        return p[63:32];
      end
      3'b011: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit fast_case(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && b == 0) return 1'b1;
    if ((op == 3'b100 || op == 3'b110) &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural mdu: answers after lat cycles, never if lat is 0
  initial begin
    mdu_ready  = 1'b0;
    mdu_result = '0;
    forever begin
      @(negedge clk);
      if (mdu_valid && lat != 0) begin
        logic [31:0] r;
        r = rv32m(mdu_op, mdu_rs1, mdu_rs2);
        repeat (lat) @(posedge clk);
        #1;
        mdu_ready  = 1'b1;
        mdu_result = r;
        @(posedge clk);
        #1;
        mdu_ready  = 1'b0;
        mdu_result = '0;
      end
    end
  end

  // Scoreboard: every issue and writeback must be expected
  always @(negedge clk) begin
    logic [66:0] ie;
    logic [37:0] we;
    if (mdu_valid) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_mdu_valid", 32'd1, 32'd0);
      end else begin
        ie = iss_q.pop_front();
        chk("mdu_op", {29'b0, mdu_op}, {29'b0, ie[66:64]});
        chk("mdu_rs1", mdu_rs1, ie[63:32]);
        chk("mdu_rs2", mdu_rs2, ie[31:0]);
      end
    end
    if (wb_valid) begin
      last_wb = wb_data;
      if (wb_q.size() == 0) begin
        chk("unexpected_wb_valid", 32'd1, 32'd0);
      end else begin
        we = wb_q.pop_front();
        if (we[37]) exp_err = 1'b1;
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, we[36:32]});
        chk("wb_data", wb_data, we[31:0]);
      end
    end
    chk("mdu_err", {31'b0, mdu_err}, {31'b0, exp_err});
  end

  task automatic set_ex(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    ex_valid   = 1'b1;
    ex_is_mdu  = 1'b1;
    ex_funct3  = op;
    ex_rs1_val = a;
    ex_rs2_val = b;
    ex_rd      = rd;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input bit to, output int stalls,
                     output logic [31:0] data);
    bit done;
    if (!fast_case(op, a, b)) iss_q.push_back({op, a, b});
    wb_q.push_back({to, rd, to ? 32'h0 : rv32m(op, a, b)});
    set_ex(op, a, b, rd);
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("stall_release", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    ex_is_mdu = 1'b0;
    data      = last_wb;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_mdu_valid"}, {31'b0, mdu_valid}, 32'd0);
    chk({tag, "_mdu_rs1"}, mdu_rs1, 32'd0);
    chk({tag, "_mdu_rs2"}, mdu_rs2, 32'd0);
    chk({tag, "_mdu_op"}, {29'b0, mdu_op}, 32'd0);
    chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
    chk({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_mdu_err"}, {31'b0, mdu_err}, 32'd0);
  endtask

  initial begin
    int          st;
    logic [31:0] d;
    rst        = 1'b1;
    ex_valid   = 1'b0;
    ex_is_mdu  = 1'b0;
    ex_funct3  = '0;
    ex_rs1_val = '0;
    ex_rs2_val = '0;
    ex_rd      = '0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;

    lat = 3;
    run(3'b000, 32'd2, 32'd10, 5'd3, 1'b0, st, d);
    chk("mul_data", d, 32'd20);
    chk("mul_stalls", st, 32'd5);

    lat = 2;
    run(3'b100, 32'd20, 32'd4, 5'd7, 1'b0, st, d);
    chk("div_data", d, 32'd5);
    chk("div_stalls", st, 32'd4);

    run(3'b100, 32'd7, 32'd0, 5'd1, 1'b0, st, d);
    chk("div0_data", d, 32'hFFFF_FFFF);
    chk("div0_stalls", st, 32'd1);
    run(3'b110, 32'd7, 32'd0, 5'd2, 1'b0, st, d);
    chk("rem0_data", d, 32'd7);
    chk("rem0_stalls", st, 32'd1);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b0, st, d);
    chk("divovf_data", d, 32'h8000_0000);
    chk("divovf_stalls", st, 32'd1);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0, st, d);
    chk("removf_data", d, 32'd0);
    run(3'b101, 32'd9, 32'd0, 5'd12, 1'b0, st, d);
    chk("divu0_data", d, 32'hFFFF_FFFF);
    run(3'b111, 32'd9, 32'd0, 5'd13, 1'b0, st, d);
    chk("remu0_data", d, 32'd9);

    lat = 1;
    run(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0, st, d);
    chk("divu_big_data", d, 32'd0);
    chk("divu_big_stalls", st, 32'd3);
    run(3'b001, 32'h8000_0000, 32'd2, 5'd15, 1'b0, st, d);
    chk("mulh_data", d, 32'hFFFF_FFFF);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b0, st, d);
    chk("mulhsu_data", d, 32'hFFFF_FFFF);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b0, st, d);
    chk("mulhu_data", d, 32'hFFFF_FFFE);

    lat = 5;
    iss_q.push_back({3'b000, 32'd4, 32'd4});
    set_ex(3'b000, 32'd4, 32'd4, 5'd5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("drain_noreq_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    lat = 1;
    run(3'b000, 32'd3, 32'd3, 5'd6, 1'b0, st, d);
    chk("after_drain_data", d, 32'd9);
    chk("after_drain_stalls", st, 32'd6);

    lat = 0;
    run(3'b000, 32'd5, 32'd5, 5'd9, 1'b1, st, d);
    chk("timeout_data", d, 32'd0);
    chk("timeout_stalls", st, 32'd65);
    chk("timeout_err", {31'b0, mdu_err}, 32'd1);
    lat = 2;
    run(3'b000, 32'd6, 32'd7, 5'd10, 1'b0, st, d);
    chk("post_err_data", d, 32'd42);
    chk("post_err_sticky", {31'b0, mdu_err}, 32'd1);

    lat = 4;
    iss_q.push_back({3'b000, 32'd8, 32'd8});
    set_ex(3'b000, 32'd8, 32'd8, 5'd11);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst      = 1'b1;
    ex_valid = 1'b0;
    exp_err  = 1'b0;
    #1;
    chk_reset("rst_busy");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("late_ready_no_wb", {31'b0, wb_valid}, 32'd0);

    lat = 1;
    run(3'b000, 32'd2, 32'd3, 5'd18, 1'b0, st, d);
    chk("recover_data", d, 32'd6);

    chk("iss_q_empty", iss_q.size(), 32'd0);
    chk("wb_q_empty", wb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
